// File: rtl/nes_reader.sv
// rtl/nes_reader.sv - NES controller poller: latch, 7 shift pulses, 8-bit frame capture.
// Optional NES_CHANGE_DETECT_EN adds a 'changed' strobe alongside valid.
`timescale 1ns/1ps
module nes_reader (
  input  logic       clk,
  input  logic       reset,
  input  logic       nes_clk_in,
  input  logic       start,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_pulse,
  output logic [7:0] buttons,
  output logic       valid,
  output logic       busy
`ifdef NES_CHANGE_DETECT_EN
  ,
  output logic       changed
`endif
);

  typedef enum logic [2:0] {IDLE, ARM, LATCH, SHIFT, DONE} state_t;

  state_t     state;
  logic       data_meta;
  logic       data_sync;
  logic       clk_prev;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       rise;
  logic       fall;
  logic [7:0] frame_next;

  assign rise       = nes_clk_in & ~clk_prev;
  assign fall       = ~nes_clk_in & clk_prev;
  // Final frame as it will look once bit7 lands; buttons and changed both use it.
  assign frame_next = {~data_sync, shift_reg[6:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
      clk_prev  <= 1'b1;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
      nes_latch <= 1'b0;
      nes_pulse <= 1'b0;
      buttons   <= 8'h00;
      valid     <= 1'b0;
      busy      <= 1'b0;
`ifdef NES_CHANGE_DETECT_EN
      changed   <= 1'b0;
`endif
    end else begin
      data_meta <= nes_data;
      data_sync <= data_meta;
      clk_prev  <= nes_clk_in;
      valid     <= 1'b0;
`ifdef NES_CHANGE_DETECT_EN
      changed   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end
        ARM: begin
          if (rise) begin
            state     <= LATCH;
            nes_latch <= 1'b1;
          end
        end
        LATCH: begin
          if (rise) begin
            nes_latch    <= 1'b0;
            shift_reg[0] <= ~data_sync;
            bit_cnt      <= 3'd1;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          if (rise && !nes_pulse) begin
            nes_pulse <= 1'b1;
          end else if (fall && nes_pulse) begin
            nes_pulse          <= 1'b0;
            shift_reg[bit_cnt] <= ~data_sync;
            // bit_cnt stops at 7 so it cannot wrap inside a frame.
            if (bit_cnt == 3'd7) begin
              state   <= DONE;
              valid   <= 1'b1;
              buttons <= frame_next;
`ifdef NES_CHANGE_DETECT_EN
              changed <= (frame_next != buttons);
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          bit_cnt <= 3'd0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_reader.sv
// tb/tb_nes_reader.sv - directed bench for nes_reader with a behavioural controller model.
// Build with NES_CHANGE_DETECT_EN defined to exercise the changed output.
`timescale 1ns/1ps
module tb_nes_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       nes_clk_in;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_pulse;
  logic [7:0] buttons;
  logic       valid;
  logic       busy;
`ifdef NES_CHANGE_DETECT_EN
  logic       changed;
`endif

  int checks = 0;
  int failures = 0;

  logic       div_en = 1'b0;
  logic       div_clk = 1'b0;
  logic       man_clk = 1'b0;
  int         div_cnt = 0;
  logic [7:0] pattern = 8'h00;
  logic [2:0] idx = 3'd0;
  int         latch_cnt = 0;
  int         pulse_cnt = 0;
  int         valid_cnt = 0;
  int         overlap_cnt = 0;
  logic       last_changed = 1'b0;

  nes_reader dut (
    .clk        (clk),
    .reset      (reset),
    .nes_clk_in (nes_clk_in),
    .start      (start),
    .nes_data   (nes_data),
    .nes_latch  (nes_latch),
    .nes_pulse  (nes_pulse),
    .buttons    (buttons),
    .valid      (valid),
    .busy       (busy)
`ifdef NES_CHANGE_DETECT_EN
    ,
    .changed    (changed)
`endif
  );

  always #5 clk = ~clk;

  // Poll clock: toggles every 4 clk cycles when the divider is enabled.
  always @(negedge clk) begin
    if (div_en) begin
      div_cnt = div_cnt + 1;
      if (div_cnt == 4) begin
        div_cnt = 0;
        div_clk = ~div_clk;
      end
    end
  end
  assign nes_clk_in = div_en ? div_clk : man_clk;

  // Controller model: latch reloads bit0 (A), each pulse advances one button; 0 = pressed.
  assign nes_data = ~pattern[idx];
  always @(posedge nes_latch or posedge nes_pulse) begin
    if (nes_latch) begin
      idx       = 3'd0;
      latch_cnt = latch_cnt + 1;
    end else begin
      idx       = idx + 3'd1;
      pulse_cnt = pulse_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (nes_latch && nes_pulse) overlap_cnt = overlap_cnt + 1;
    if (valid) valid_cnt = valid_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input int target, input int budget);
    int n;
    n = 0;
    while (valid_cnt < target && n < budget) begin
      @(negedge clk);
      #1;
      n = n + 1;
    end
    if (valid_cnt < target) check("valid_timeout", valid_cnt, target);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] pat, input logic [7:0] exp);
    int lb, pb, vb;
    lb = latch_cnt;
    pb = pulse_cnt;
    vb = valid_cnt;
    pattern = pat;
    pulse_start();
    wait_valid(vb + 1, 400);
`ifdef NES_CHANGE_DETECT_EN
    last_changed = changed;
`endif
    check({tag, "_buttons"}, buttons, exp);
    check({tag, "_busy_at_valid"}, busy, 1);
    @(negedge clk);
    #1;
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_valid_one_cycle"}, valid, 0);
    check({tag, "_latches"}, latch_cnt - lb, 1);
    check({tag, "_pulses"}, pulse_cnt - pb, 7);
    check({tag, "_valids"}, valid_cnt - vb, 1);
  endtask

  initial begin
    int lb, pb, vb, n;
    repeat (3) @(negedge clk);
    #1;
    check("rst_latch", nes_latch, 0);
    check("rst_pulse", nes_pulse, 0);
    check("rst_buttons", buttons, 8'h00);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    reset  = 1'b1;
    div_en = 1'b1;

    run_frame("a_start", 8'h09, 8'h09);
    run_frame("none", 8'h00, 8'h00);
    run_frame("all", 8'hFF, 8'hFF);

    // A second start mid-frame must be dropped, not queued.
    lb = latch_cnt;
    vb = valid_cnt;
    pattern = 8'h3C;
    pulse_start();
    repeat (30) @(negedge clk);
    #1;
    check("midframe_busy", busy, 1);
    pulse_start();
    wait_valid(vb + 1, 400);
    check("ignored_buttons", buttons, 8'h3C);
    repeat (120) @(negedge clk);
    #1;
    check("ignored_valids", valid_cnt - vb, 1);
    check("ignored_latches", latch_cnt - lb, 1);
    check("ignored_idle", busy, 0);

    // Start held high: back-to-back frames.
    lb = latch_cnt;
    pb = pulse_cnt;
    vb = valid_cnt;
    pattern = 8'hA5;
    @(negedge clk);
    start = 1'b1;
    wait_valid(vb + 2, 800);
    start = 1'b0;
    check("b2b_buttons", buttons, 8'hA5);
    check("b2b_latches", latch_cnt - lb, 2);
    check("b2b_pulses", pulse_cnt - pb, 14);
    repeat (120) @(negedge clk);
    #1;
    check("b2b_valids", valid_cnt - vb, 2);
    check("b2b_idle", busy, 0);

    // Reset during SHIFT after three pulses aborts the frame.
    pb = pulse_cnt;
    vb = valid_cnt;
    pattern = 8'h3C;
    pulse_start();
    n = 0;
    while (pulse_cnt - pb < 3 && n < 400) begin
      @(negedge clk);
      n = n + 1;
    end
    check("abort_reached_pulse3", pulse_cnt - pb, 3);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_latch", nes_latch, 0);
    check("abort_pulse", nes_pulse, 0);
    check("abort_buttons", buttons, 8'h00);
    check("abort_valid", valid, 0);
    check("abort_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (150) @(negedge clk);
    #1;
    check("abort_no_valid", valid_cnt - vb, 0);
    check("abort_buttons_hold", buttons, 8'h00);
    run_frame("after_abort", 8'h5A, 8'h5A);

    // Poll clock high through reset release: latch only on a genuine rising edge.
    @(negedge clk);
    div_en  = 1'b0;
    man_clk = 1'b1;
    reset   = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    lb = latch_cnt;
    vb = valid_cnt;
    pattern = 8'h81;
    pulse_start();
    repeat (20) @(negedge clk);
    #1;
    check("hi_no_latch", latch_cnt - lb, 0);
    check("hi_armed_busy", busy, 1);
    man_clk = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("hi_fall_no_latch", latch_cnt - lb, 0);
    man_clk = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("hi_rise_latch", nes_latch, 1);
    div_en = 1'b1;
    wait_valid(vb + 1, 400);
    check("hi_buttons", buttons, 8'h81);

    check("no_overlap", overlap_cnt, 0);

`ifdef NES_CHANGE_DETECT_EN
    run_frame("chg0", 8'h01, 8'h01);
    check("chg0_changed", last_changed, 1);
    run_frame("chg1", 8'h01, 8'h01);
    check("chg1_changed", last_changed, 0);
    run_frame("chg2", 8'h80, 8'h80);
    check("chg2_changed", last_changed, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
